// File: rtl/core_inst_sequencer.sv
// Instruction-word sequencer for one core compute pass: xmem fill, L0 load, execute, drain, accumulate.
// Optional DRAIN idle watchdog enabled by defining CORE_SEQ_TIMEOUT_EN.
module core_inst_sequencer #(
  parameter int ROW     = 8,
  parameter int L0_BW   = 8,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       cfg_xbase,
  input  logic [ADDR_W-1:0]       cfg_xlen,
  input  logic [ADDR_W-1:0]       cfg_pbase,
  input  logic [ADDR_W-1:0]       cfg_olen,
  input  logic                    cfg_kernel,
  input  logic                    cfg_acc,
  input  logic                    cfg_relu,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [L0_BW*ROW-1:0]    in_data,
  input  logic                    ofifo_valid,
  output logic [34:0]             inst,
  output logic [L0_BW*ROW-1:0]    d_xmem,
  output logic                    sfp_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;
  localparam logic [ADDR_W-1:0] A0 = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_XWR, S_L0WR, S_EXEC, S_DRAIN, S_ACC, S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt, rcnt;
  logic [ADDR_W-1:0] xbase_q, xlen_q, pbase_q, olen_q;
  logic              kernel_q, acc_q, relu_q;
  logic [CW-1:0]     xlen_c, olen_c, cnt_inc, rd_inc;
  logic [ADDR_W-1:0] xa, pa;
  logic              drain_rd, drain_wr;
  logic [1:0]        op;

  function automatic logic [34:0] word(
    input logic [6:0]        lo,
    input logic              xc,
    input logic              xw,
    input logic [ADDR_W-1:0] xad,
    input logic              pc,
    input logic              pw,
    input logic [ADDR_W-1:0] pad,
    input logic [1:0]        hi
  );
    word = {hi, pc, pw, pad, xc, xw, xad, lo};
  endfunction

  assign xlen_c   = {1'b0, xlen_q};
  assign olen_c   = {1'b0, olen_q};
  assign cnt_inc  = cnt + CW'(1);
  assign xa       = xbase_q + cnt[ADDR_W-1:0];
  assign pa       = pbase_q + cnt[ADDR_W-1:0];
  assign drain_rd = ofifo_valid && (rcnt < olen_c);
  // a read issued last cycle lands in pmem this cycle
  assign drain_wr = inst[6];
  assign rd_inc   = {{(CW-1){1'b0}}, drain_rd};
  assign op       = kernel_q ? 2'b01 : 2'b10;

`ifdef CORE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      inst      <= IDLE_W;
      d_xmem    <= '0;
      in_ready  <= 1'b0;
      sfp_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      rcnt      <= '0;
      xbase_q   <= '0;
      xlen_q    <= '0;
      pbase_q   <= '0;
      olen_q    <= '0;
      kernel_q  <= 1'b0;
      acc_q     <= 1'b0;
      relu_q    <= 1'b0;
`ifdef CORE_SEQ_TIMEOUT_EN
      tcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      sfp_valid <= inst[33];
`ifdef CORE_SEQ_TIMEOUT_EN
      tcnt      <= '0;
`endif
      case (state)
        S_IDLE: begin
          inst <= IDLE_W;
          busy <= 1'b0;
          if (start) begin
            xbase_q  <= cfg_xbase;
            xlen_q   <= cfg_xlen;
            pbase_q  <= cfg_pbase;
            olen_q   <= cfg_olen;
            kernel_q <= cfg_kernel;
            acc_q    <= cfg_acc;
            relu_q   <= cfg_relu;
            busy     <= 1'b1;
            cnt      <= '0;
            rcnt     <= '0;
`ifdef CORE_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            if (cfg_xlen != A0) begin
              state    <= S_XWR;
              in_ready <= 1'b1;
            end else if (cfg_olen != A0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_XWR: begin
          if (in_valid && in_ready) begin
            inst   <= word(7'd0, 1'b0, 1'b0, xa, 1'b1, 1'b1, A0, 2'b00);
            d_xmem <= in_data;
            if (cnt_inc == xlen_c) begin
              in_ready <= 1'b0;
              state    <= S_L0WR;
              cnt      <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            inst <= IDLE_W;
          end
        end
        S_L0WR: begin
          if (cnt == xlen_c) begin
            inst  <= word(7'b0000100, 1'b1, 1'b1, A0, 1'b1, 1'b1, A0, 2'b00);
            state <= S_EXEC;
            cnt   <= '0;
          end else begin
            inst <= word({4'd0, cnt != '0, 2'b00}, 1'b0, 1'b1, xa,
                         1'b1, 1'b1, A0, 2'b00);
            cnt  <= cnt_inc;
          end
        end
        S_EXEC: begin
          if (cnt == xlen_c) begin
            inst <= IDLE_W;
            cnt  <= '0;
            rcnt <= '0;
            if (olen_q != A0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            inst <= word({4'b0001, 1'b0, op}, 1'b1, 1'b1, A0,
                         1'b1, 1'b1, A0, 2'b00);
            cnt  <= cnt_inc;
          end
        end
        S_DRAIN: begin
          if (cnt == olen_c) begin
            inst <= IDLE_W;
            cnt  <= '0;
            if (acc_q) begin
              state <= S_ACC;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
`ifdef CORE_SEQ_TIMEOUT_EN
          else if (!ofifo_valid && !drain_wr &&
                   tcnt == TW'(TIMEOUT - 1)) begin
            inst  <= IDLE_W;
            err_q <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end
`endif
          else begin
            inst <= word({drain_rd, 6'd0}, 1'b1, 1'b1, A0, !drain_wr,
                         !drain_wr, drain_wr ? pa : A0, 2'b00);
            rcnt <= rcnt + rd_inc;
            if (drain_wr) cnt <= cnt_inc;
          end
`ifdef CORE_SEQ_TIMEOUT_EN
          tcnt <= ofifo_valid ? '0 : tcnt + TW'(1);
`endif
        end
        S_ACC: begin
          if (cnt == olen_c) begin
            inst  <= IDLE_W;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            inst <= word(7'd0, 1'b1, 1'b1, A0, 1'b0, 1'b1, pa,
                         {relu_q, 1'b1});
            cnt  <= cnt_inc;
          end
        end
        S_DONE: begin
          inst  <= IDLE_W;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Randomized pass-level bench for core_inst_sequencer.
// Traces every cycle of a pass and checks it against the phase rules.
module tb_core_inst_sequencer;

  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] cfg_xbase, cfg_xlen, cfg_pbase, cfg_olen;
  logic        cfg_kernel, cfg_acc, cfg_relu;
  logic        in_valid, in_ready, ofifo_valid;
  logic [63:0] in_data, d_xmem;
  logic [34:0] inst;
  logic        sfp_valid, busy, done, err;

  always #5 clk = ~clk;

  core_inst_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_xbase(cfg_xbase), .cfg_xlen(cfg_xlen),
    .cfg_pbase(cfg_pbase), .cfg_olen(cfg_olen),
    .cfg_kernel(cfg_kernel), .cfg_acc(cfg_acc), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ofifo_valid(ofifo_valid), .inst(inst), .d_xmem(d_xmem),
    .sfp_valid(sfp_valid), .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [34:0] w;
    logic [63:0] dx;
    logic [63:0] din;
    logic        sfp, dn, bsy, hs, er;
  } ent_t;

  ent_t tr[$];

  task automatic drive(input int ivm, input int ovm, input int c);
    in_data = {$urandom(), $urandom()};
    case (ivm)
      0:       in_valid = 1'b1;
      1:       in_valid = (c % 2 == 1);
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    case (ovm)
      0:       ofifo_valid = 1'b1;
      3:       ofifo_valid = 1'b0;
      default: ofifo_valid = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic record();
    ent_t e;
    e.w   = inst;
    e.dx  = d_xmem;
    e.din = in_data;
    e.sfp = sfp_valid;
    e.dn  = done;
    e.bsy = busy;
    e.hs  = in_valid && in_ready;
    e.er  = err;
    tr.push_back(e);
  endtask

  task automatic run_pass(input logic [10:0] xb, input logic [10:0] xl,
                          input logic [10:0] pb, input logic [10:0] ol,
                          input logic k, input logic a, input logic r,
                          input int ivm, input int ovm);
    logic [63:0] sent[$];
    logic [34:0] w;
    logic        seen, fin, isrd, isacc;
    int bound, nxw, nxr, nl0w, nexe, npw, nrd, nacc, nsfp, ndone;
    int both, seq_bad, addr_bad, idle_bad, op_bad, ord_bad, nerr, dn_bad;
    int nacc_exp;
    tr.delete();
    seen = 1'b0; fin = 1'b0;
    bound = 40 * (int'(xl) + int'(ol)) + 100;
    @(negedge clk);
    cfg_xbase = xb; cfg_xlen = xl; cfg_pbase = pb; cfg_olen = ol;
    cfg_kernel = k; cfg_acc = a; cfg_relu = r;
    start = 1'b1;
    drive(ivm, ovm, 0);
    for (int c = 0; c < bound; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start = 1'b0;
        drive(ivm, ovm, c);
      end
      record();
      if (seen) begin
        fin = 1'b1;
        break;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0;
    chk("pass_finished", 64'(fin), 64'd1);

    nxw = 0; nxr = 0; nl0w = 0; nexe = 0; npw = 0; nrd = 0; nacc = 0;
    nsfp = 0; ndone = 0; both = 0; seq_bad = 0; addr_bad = 0;
    idle_bad = 0; op_bad = 0; ord_bad = 0; nerr = 0; dn_bad = 0;
    foreach (tr[i]) if (tr[i].hs) sent.push_back(tr[i].din);
    foreach (tr[i]) begin
      w = tr[i].w;
      if (i >= 1 && tr[i].er) nerr++;
      if (!w[19] && !w[32]) both++;
      if (tr[i].hs && (i + 1 >= tr.size() || tr[i+1].w[19] ||
                       tr[i+1].w[18])) seq_bad++;
      if (!w[19] && !w[18]) begin
        if (i == 0 || !tr[i-1].hs) seq_bad++;
        if (w[17:7] != 11'(int'(xb) + nxw)) addr_bad++;
        if (nxw >= sent.size() || tr[i].dx !== sent[nxw]) addr_bad++;
        nxw++;
      end else if (i >= 1 && tr[i].bsy && nxr == 0 && nxw < int'(xl)) begin
        if (w !== IDLE_W) idle_bad++;
      end
      if (!w[19] && w[18]) begin
        if (w[17:7] != 11'(int'(xb) + nxr)) addr_bad++;
        if (nxw != int'(xl)) ord_bad++;
        nxr++;
      end
      if (w[2]) begin
        isrd = (i >= 1) && !tr[i-1].w[19] && tr[i-1].w[18];
        if (!isrd) seq_bad++;
        nl0w++;
      end
      if (w[3]) begin
        if (w[1:0] != (k ? 2'b01 : 2'b10)) op_bad++;
        if (nl0w != int'(xl)) ord_bad++;
        nexe++;
      end
      if (w[6]) begin
        if (nexe != int'(xl)) ord_bad++;
        nrd++;
      end
      if (!w[32] && !w[31]) begin
        if (i == 0 || !tr[i-1].w[6]) seq_bad++;
        if (w[30:20] != 11'(int'(pb) + npw)) addr_bad++;
        npw++;
      end
      if (!w[32] && w[31]) begin
        if (w[30:20] != 11'(int'(pb) + nacc)) addr_bad++;
        if (!w[33] || w[34] != r) op_bad++;
        if (npw != int'(ol)) ord_bad++;
        nacc++;
      end
      if (tr[i].sfp) begin
        isacc = (i >= 1) && !tr[i-1].w[32] && tr[i-1].w[31];
        if (!isacc) seq_bad++;
        nsfp++;
      end
      if (tr[i].dn) begin
        ndone++;
        if (w !== IDLE_W || !tr[i].bsy) dn_bad++;
        if (i + 1 < tr.size() && tr[i+1].bsy) dn_bad++;
      end
    end
    nacc_exp = a ? int'(ol) : 0;
    chk("xmem_writes", 64'(nxw), 64'(xl));
    chk("handshakes", 64'(sent.size()), 64'(xl));
    chk("xmem_reads", 64'(nxr), 64'(xl));
    chk("l0_writes", 64'(nl0w), 64'(xl));
    chk("exec_cycles", 64'(nexe), 64'(xl));
    chk("ofifo_reads", 64'(nrd), 64'(ol));
    chk("pmem_writes", 64'(npw), 64'(ol));
    chk("acc_reads", 64'(nacc), 64'(nacc_exp));
    chk("sfp_pulses", 64'(nsfp), 64'(nacc_exp));
    chk("done_pulses", 64'(ndone), 64'd1);
    chk("done_shape", 64'(dn_bad), 64'd0);
    chk("dual_sram", 64'(both), 64'd0);
    chk("latency", 64'(seq_bad), 64'd0);
    chk("addr_data", 64'(addr_bad), 64'd0);
    chk("xwr_gap_idle", 64'(idle_bad), 64'd0);
    chk("op_bits", 64'(op_bad), 64'd0);
    chk("phase_order", 64'(ord_bad), 64'd0);
    chk("err_clear", 64'(nerr), 64'd0);
  endtask

  initial begin
    logic seen_any;
    int   didx;
    logic derr;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0;
    in_data = '0; cfg_xbase = '0; cfg_xlen = '0; cfg_pbase = '0;
    cfg_olen = '0; cfg_kernel = 1'b0; cfg_acc = 1'b0; cfg_relu = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inst", 64'(inst), 64'(IDLE_W));
    chk("rst_dxmem", d_xmem, 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_flags", {60'd0, sfp_valid, busy, done, err}, 64'd0);
    reset = 1'b1;

    @(negedge clk);
    cfg_xbase = 11'd5; cfg_xlen = 11'd4; cfg_olen = 11'd2;
    start = 1'b1; in_valid = 1'b1; in_data = {$urandom(), $urandom()};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_xwr_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_inst", 64'(inst), 64'(IDLE_W));
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd0);
    seen_any = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_any = seen_any | done | busy;
    end
    chk("abort_no_done", 64'(seen_any), 64'd0);

    run_pass(11'd2046, 11'd4, 11'd100, 11'd2, 1'b0, 1'b0, 1'b0, 0, 0);
    run_pass(11'd10, 11'd4, 11'd30, 11'd1, 1'b0, 1'b0, 1'b0, 1, 0);
    run_pass(11'd7, 11'd3, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_pass(11'd7, 11'd3, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_pass(11'd0, 11'd2, 11'd16, 11'd8, 1'b0, 1'b1, 1'b1, 2, 2);
    run_pass(11'd0, 11'd0, 11'd2044, 11'd6, 1'b0, 1'b1, 1'b0, 0, 2);
    run_pass(11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int p = 0; p < 8; p++) begin
      run_pass(11'($urandom_range(2030, 2047)), 11'($urandom_range(0, 8)),
               11'($urandom_range(0, 2047)), 11'($urandom_range(0, 10)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2, 2);
    end

`ifdef CORE_SEQ_TIMEOUT_EN
    didx = -1; derr = 1'b0;
    @(negedge clk);
    cfg_xlen = 11'd0; cfg_olen = 11'd3; cfg_acc = 1'b1;
    start = 1'b1; ofifo_valid = 1'b0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        didx = c;
        derr = err;
        break;
      end
    end
    chk("to_done_cycle", 64'(didx), 64'(TO + 1));
    chk("to_err", 64'(derr), 64'd1);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 64'(err), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    run_pass(11'd3, 11'd2, 11'd8, 11'd3, 1'b0, 1'b0, 1'b0, 0, 0);
`else
    didx = 0; derr = 1'b0;
    chk("err_tied", 64'(err | derr), 64'(didx));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
